// File: rtl/switch_input_if.sv
// Board input bundle: raw switches/buttons and IO-read strobe going in, packed switch word out.
//   sw_raw  [7:0]  asynchronous slide switches
//   btn_raw [3:0]  asynchronous push buttons, active-high
//   rd_ack         one-cycle pulse when the CPU reads the IO region
//   switchs [63:0] registered switch word for the data-memory/IO stage
interface switch_input_if;
   logic [7:0]  sw_raw;
   logic [3:0]  btn_raw;
   logic        rd_ack;
   logic [63:0] switchs;

   modport master (
      output sw_raw,
      output btn_raw,
      output rd_ack,
      input  switchs
   );

   modport slave (
      input  sw_raw,
      input  btn_raw,
      input  rd_ack,
      output switchs
   );
endinterface

// File: rtl/switch_input.sv
// Switch/button front end: synchronizes and debounces 8 slide switches and 4 push buttons,
// and keeps a sticky "pressed since last read" flag per button, cleared by an IO read.
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    switch_input_if.slave (sw_raw, btn_raw, rd_ack in; switchs out)
//   switchs = {48'h0, sticky[3:0], stable_btn[3:0], stable_sw[7:0]}
module switch_input #(
   parameter int unsigned DB_CYCLES = 50000,
   parameter int unsigned CNT_W     = 16
) (
   input logic            clk,
   input logic            reset,
   switch_input_if.slave  bus
);

   localparam int unsigned NumIn = 12;
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [NumIn-1:0] raw;
   logic [NumIn-1:0] sync1_d, sync1_q;
   logic [NumIn-1:0] sync2_d, sync2_q;
   logic [NumIn-1:0] stable_d, stable_q;
   logic [CNT_W-1:0] cnt_d [NumIn];
   logic [CNT_W-1:0] cnt_q [NumIn];
   logic [3:0]       sticky_d, sticky_q;
   logic [3:0]       btn_rise;

   assign raw = {bus.btn_raw, bus.sw_raw};

   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < NumIn; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            // Any agreement with the stable value restarts the hold window.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            // DB_CYCLES consecutive differing cycles seen, including this one.
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
         end
      end

      // Rise is taken from the next stable value so the flag appears together with the button.
      btn_rise = stable_d[11:8] & ~stable_q[11:8];
      // Set wins over the read-clear.
      sticky_d = btn_rise | (bus.rd_ack ? 4'b0000 : sticky_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         sticky_q <= '0;
         for (int i = 0; i < NumIn; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         sticky_q <= sticky_d;
         for (int i = 0; i < NumIn; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Output is a pure wiring of state flops; no input reaches it combinationally.
   assign bus.switchs = {48'h0, sticky_q, stable_q};

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input with DB_CYCLES=4. Stimulus schedules expected switch words
// against an absolute edge count; a monitor on the falling edge pops and compares them.
module tb_switch_input;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int unsigned cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   switch_input_if sw_if ();

   switch_input #(
      .DB_CYCLES (4),
      .CNT_W     (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sw_if.slave)
   );

   typedef struct {
      int unsigned cyc;
      logic [63:0] mask;
      logic [63:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];

   // Expect (switchs & mask) == val at the falling edge after absolute edge 'at'.
   task automatic expect_at(input int unsigned at, input logic [63:0] mask,
                            input logic [63:0] val, input string name);
      exp_t e;
      e.cyc  = at;
      e.mask = mask;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int unsigned at);
      while (cyc < at) @(negedge clk);
   endtask

   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            n_tests++;
            if ((sw_if.switchs & sb[i].mask) !== sb[i].val) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h (mask %h) at edge %0d", sb[i].name,
                        sw_if.switchs & sb[i].mask, sb[i].val, sb[i].mask, cyc);
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: check missed, expected %h at edge %0d", sb[i].name,
                     sb[i].val, sb[i].cyc);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   localparam logic [63:0] All = {64{1'b1}};
   localparam logic [63:0] Lo8 = 64'h00FF;
   localparam logic [63:0] Hi8 = 64'hFF00;
   localparam logic [63:0] Lo16 = 64'hFFFF;

   initial begin
      int unsigned c;
      sw_if.sw_raw  = 8'h00;
      sw_if.btn_raw = 4'h0;
      sw_if.rd_ack  = 1'b0;
      @(negedge clk);

      // Reset with switches high: zero during and right after; the short FF blip is rejected.
      c = cyc;
      reset = 1'b1;
      sw_if.sw_raw = 8'hFF;
      sw_if.rd_ack = 1'b1;
      expect_at(c + 1, All, 64'h0, "rst_during_1");
      expect_at(c + 2, All, 64'h0, "rst_during_2");
      wait_until(c + 2);
      reset = 1'b0;
      sw_if.rd_ack = 1'b0;
      expect_at(c + 3, All, 64'h0, "rst_after");
      wait_until(c + 3);
      sw_if.sw_raw = 8'h00;
      expect_at(c + 8, All, 64'h0, "rst_blip_rejected");
      wait_until(c + 10);

      // Held A5: still old value after edge 5, new value after edge 6.
      c = cyc;
      sw_if.sw_raw = 8'hA5;
      expect_at(c + 5, Lo8, 64'h00, "sw_a5_edge5");
      expect_at(c + 6, Lo8, 64'hA5, "sw_a5_edge6");
      expect_at(c + 7, All, 64'hA5, "sw_a5_word");
      wait_until(c + 8);

      // Button 0 high for only 3 cycles: no button or sticky change.
      c = cyc;
      sw_if.btn_raw = 4'h1;
      expect_at(c + 3, Hi8, 64'h0, "btn0_glitch_a");
      expect_at(c + 6, Hi8, 64'h0, "btn0_glitch_b");
      expect_at(c + 9, Hi8, 64'h0, "btn0_glitch_c");
      wait_until(c + 3);
      sw_if.btn_raw = 4'h0;
      wait_until(c + 10);

      // Button 1 held 10 cycles, released, then one read clears the sticky flag.
      c = cyc;
      sw_if.btn_raw = 4'h2;
      expect_at(c + 5, Hi8, 64'h0000, "btn1_before");
      expect_at(c + 6, Hi8, 64'h2200, "btn1_press");
      expect_at(c + 15, Hi8, 64'h2200, "btn1_held");
      expect_at(c + 16, Hi8, 64'h2000, "btn1_release_sticky");
      expect_at(c + 17, Hi8, 64'h2000, "btn1_sticky_hold");
      expect_at(c + 18, Hi8, 64'h0000, "btn1_read_clear");
      wait_until(c + 10);
      sw_if.btn_raw = 4'h0;
      wait_until(c + 17);
      sw_if.rd_ack = 1'b1;
      wait_until(c + 18);
      sw_if.rd_ack = 1'b0;
      wait_until(c + 20);

      // Button 2: read in the very cycle the flag sets, set must win.
      c = cyc;
      sw_if.btn_raw = 4'h4;
      expect_at(c + 6, Hi8, 64'h4400, "btn2_set_vs_clear");
      expect_at(c + 7, Hi8, 64'h4400, "btn2_set_kept");
      expect_at(c + 13, Hi8, 64'h4400, "btn2_held");
      expect_at(c + 14, Hi8, 64'h4000, "btn2_release");
      expect_at(c + 15, Hi8, 64'h4000, "btn2_sticky_hold");
      expect_at(c + 16, Hi8, 64'h0000, "btn2_read_clear");
      wait_until(c + 5);
      sw_if.rd_ack = 1'b1;
      wait_until(c + 6);
      sw_if.rd_ack = 1'b0;
      wait_until(c + 8);
      sw_if.btn_raw = 4'h0;
      wait_until(c + 15);
      sw_if.rd_ack = 1'b1;
      wait_until(c + 16);
      sw_if.rd_ack = 1'b0;
      wait_until(c + 18);

      // sw[3] change interrupted by reset at count 2; full count restarts after release.
      c = cyc;
      sw_if.sw_raw = 8'hAD;
      wait_until(c + 4);
      reset = 1'b1;
      sw_if.rd_ack = 1'b1;
      expect_at(c + 5, All, 64'h0, "mid_reset_zero");
      wait_until(c + 5);
      reset = 1'b0;
      sw_if.rd_ack = 1'b0;
      expect_at(c + 10, All, 64'h0, "post_reset_edge5");
      expect_at(c + 11, All, 64'hAD, "post_reset_edge6");
      wait_until(c + 13);

      // Independent timelines: sw[7] drops, button 3 rises two cycles later.
      c = cyc;
      sw_if.sw_raw = 8'h2D;
      expect_at(c + 5, Lo16, 64'h00AD, "indep_edge5");
      expect_at(c + 6, Lo16, 64'h002D, "indep_sw7");
      expect_at(c + 7, Lo16, 64'h002D, "indep_btn_pending");
      expect_at(c + 8, All, 64'h882D, "indep_btn3");
      wait_until(c + 2);
      sw_if.btn_raw = 4'h8;
      wait_until(c + 12);

      foreach (sb[k]) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: never checked, expected %h at edge %0d", sb[k].name, sb[k].val,
                  sb[k].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
